// File: rtl/alu_pkg.sv
// Shared JAM-1 ALU definitions: data width, carry-in select encodings, flag layout.
package alu_pkg;

  localparam int unsigned ALU_W  = 8;
  localparam int unsigned FLAG_W = 4;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [1:0] {
    CIN_ZERO = 2'b00,
    CIN_ONE  = 2'b01,
    CIN_FLAG = 2'b10,
    CIN_RSVD = 2'b11
  } cin_sel_e;

  // Architectural flag word, MSB first: {V,N,C,Z}
  typedef struct packed {
    logic v;
    logic n;
    logic c;
    logic z;
  } flags_t;

endpackage

// File: rtl/alu_adder8.sv
// Combinational JAM-1 adder: sum plus V/N/C/Z from lhs, rhs and carry-in.
module alu_adder8
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_c,
  output flags_t           flags_c
);

  logic [WIDTH:0] full;

  // Full-width sum so the carry-out survives before the result is sliced off
  always_comb begin
    full      = (WIDTH+1)'(lhs) + (WIDTH+1)'(rhs) + (WIDTH+1)'(cin);
    sum_c     = full[WIDTH-1:0];
    flags_c.c = full[WIDTH];
    flags_c.z = (full[WIDTH-1:0] == '0);
    flags_c.n = full[WIDTH-1];
    flags_c.v = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (full[WIDTH-1] != lhs[WIDTH-1]);
  end

endmodule

// File: rtl/alu_adder_stage.sv
// Registered add/carry stage of the JAM-1 ALU pipeline with stall and flush.
module alu_adder_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              ValidIn,
  input  logic [WIDTH-1:0]  LHSIn,
  input  logic [WIDTH-1:0]  RHSIn,
  input  logic [1:0]        CarrySelect,
  input  logic              FlagsWrite,
  output logic [WIDTH-1:0]  ResultOut,
  output logic              ValidOut,
  output logic [FLAG_W-1:0] FlagsOut
);

  logic             cin;
  logic             accept;
  logic [WIDTH-1:0] sum_c;
  flags_t           flags_c;

  // Carry-in source; the flag option reads the committed C so chained adds need no bubble
  always_comb begin
    cin = 1'b0;
    unique case (cin_sel_e'(CarrySelect))
      CIN_ZERO: cin = 1'b0;
      CIN_ONE:  cin = 1'b1;
      CIN_FLAG: cin = FlagsOut[FLAG_C];
      CIN_RSVD: cin = 1'b0;
      default:  cin = 1'b0;
    endcase
  end

  always_comb begin
    accept = ValidIn && !Stall && !Flush;
  end

  alu_adder8 #(
    .WIDTH (WIDTH)
  ) u_adder (
    .lhs     (LHSIn),
    .rhs     (RHSIn),
    .cin     (cin),
    .sum_c   (sum_c),
    .flags_c (flags_c)
  );

  // Flush beats stall; a stall freezes everything, otherwise valid tracks ValidIn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ValidOut <= 1'b0;
    end else if (Flush) begin
      ValidOut <= 1'b0;
    end else if (!Stall) begin
      ValidOut <= ValidIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ResultOut <= '0;
    end else if (accept) begin
      ResultOut <= sum_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FlagsOut <= '0;
    end else if (accept && FlagsWrite) begin
      FlagsOut <= flags_c;
    end
  end

endmodule

// File: tb/tb_alu_adder_stage.sv
// Bench for alu_adder_stage: directed cases plus randomized traffic against an arithmetic model.
module tb_alu_adder_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Stall;
  logic       Flush;
  logic       ValidIn;
  logic [7:0] LHSIn;
  logic [7:0] RHSIn;
  logic [1:0] CarrySelect;
  logic       FlagsWrite;
  logic [7:0] ResultOut;
  logic       ValidOut;
  logic [3:0] FlagsOut;

  int n_vec = 0;
  int n_err = 0;

  int m_res   = 0;
  int m_val   = 0;
  int m_flags = 0;

  alu_adder_stage #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Stall       (Stall),
    .Flush       (Flush),
    .ValidIn     (ValidIn),
    .LHSIn       (LHSIn),
    .RHSIn       (RHSIn),
    .CarrySelect (CarrySelect),
    .FlagsWrite  (FlagsWrite),
    .ResultOut   (ResultOut),
    .ValidOut    (ValidOut),
    .FlagsOut    (FlagsOut)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] l, input logic [7:0] r,
                       input logic [1:0] cs, input logic fw, input logic st, input logic fl);
    ValidIn = v; LHSIn = l; RHSIn = r; CarrySelect = cs;
    FlagsWrite = fw; Stall = st; Flush = fl;
  endtask

  // Arithmetic reference: what the registers should hold after the coming edge
  task automatic model_step();
    int a, b, ci, s, r, c, z, n, v;
    if (Flush) begin
      m_val = 0;
    end else if (!Stall) begin
      if (ValidIn) begin
        a  = int'(LHSIn);
        b  = int'(RHSIn);
        ci = (CarrySelect == 2'd1) ? 1 :
             (CarrySelect == 2'd2) ? ((m_flags / 2) % 2) : 0;
        s  = a + b + ci;
        r  = s % 256;
        c  = s / 256;
        z  = (r == 0) ? 1 : 0;
        n  = r / 128;
        v  = ((a / 128) == (b / 128) && (n != a / 128)) ? 1 : 0;
        m_res = r;
        m_val = 1;
        if (FlagsWrite) m_flags = v * 8 + n * 4 + c * 2 + z;
      end else begin
        m_val = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_res"},   ResultOut,         8'(m_res));
    check_eq({tag, "_valid"}, 8'(ValidOut),      8'(m_val));
    check_eq({tag, "_flags"}, 8'(FlagsOut),      8'(m_flags));
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 8'h00, 8'h00, 2'b00, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_res",   ResultOut,    8'h00);
    check_eq("reset_valid", 8'(ValidOut), 8'h00);
    check_eq("reset_flags", 8'(FlagsOut), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Signed overflow into the sign bit
    drive(1, 8'h7F, 8'h01, 2'b00, 1, 0, 0);
    cyc("ovf");
    check_eq("ovf_const_res",   ResultOut,    8'h80);
    check_eq("ovf_const_flags", 8'(FlagsOut), 8'h0C);

    // Carry out, then chained carry-in from the committed C
    drive(1, 8'hFF, 8'h01, 2'b00, 1, 0, 0);
    cyc("carry");
    check_eq("carry_const_flags", 8'(FlagsOut), 8'h03);
    drive(1, 8'h00, 8'h00, 2'b10, 1, 0, 0);
    cyc("chain");
    check_eq("chain_const_res",   ResultOut,    8'h01);
    check_eq("chain_const_flags", 8'(FlagsOut), 8'h00);

    // Stall holds everything for three cycles
    drive(1, 8'h10, 8'h20, 2'b00, 1, 0, 0);
    cyc("pre_stall");
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'($urandom), 8'($urandom), 2'($urandom), 1, 1, 0);
      cyc("stall");
      check_eq("stall_const_res", ResultOut, 8'h30);
    end
    drive(1, 8'h01, 8'h01, 2'b00, 1, 0, 0);
    cyc("post_stall");
    check_eq("post_stall_const_res", ResultOut, 8'h02);

    // Flush with stall: nothing commits
    drive(1, 8'h80, 8'h80, 2'b00, 1, 1, 1);
    cyc("flush_stall");
    check_eq("flush_const_flags", 8'(FlagsOut), 8'h00);

    // FlagsWrite with no valid op
    drive(0, 8'hFF, 8'h01, 2'b00, 1, 0, 0);
    cyc("novalid");

    // Asynchronous reset mid-cycle after a valid op
    drive(1, 8'hFF, 8'hFF, 2'b01, 1, 0, 0);
    cyc("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    m_res = 0; m_val = 0; m_flags = 0;
    check_model("async_reset");
    @(posedge clk);
    #1;
    check_model("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 8'h00, 8'h00, 2'b00, 0, 0, 0);
    cyc("reset_idle");

    // Randomized traffic including reserved carry select, stalls and flushes
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
            2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 7) == 0));
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
